// File: rtl/lms_orca_adf_word_writer.sv
// Sequencer that pushes whole ADF register words through the 8-bit ADF SPI master core's Avalon port.
// Every core access is three cycles: two strobe cycles with bus held constant, then a recovery cycle.
module lms_orca_adf_word_writer #(
  parameter int          NBYTES     = 3,
  parameter logic [15:0] SLAVE_MASK = 16'h0001,
  parameter int          LE_GAP     = 10,
  parameter int          POLL_LIMIT = 4095
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [8*NBYTES-1:0]   word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  busy,
  output logic                  timeout_err,
  output logic                  m_spi_select,
  output logic [2:0]            m_mem_addr,
  output logic [15:0]           m_data_from_cpu,
  output logic                  m_write_n,
  output logic                  m_read_n,
  input  logic [15:0]           m_data_to_cpu
);
  localparam int W  = 8*NBYTES;
  localparam int BW = $clog2(NBYTES+1);
  localparam int PW = 12;
  localparam int GW = (LE_GAP > 1) ? $clog2(LE_GAP) : 1;

  typedef enum logic [3:0] {
    IDLE, SSEL_WR, CTRL_ON, POLL_TRDY, DATA_WR, POLL_TMT, CTRL_OFF, CLR_STAT, GAP
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      phase;
  logic [W-1:0]    shreg;
  logic [BW-1:0]   byte_idx;
  logic [PW-1:0]   poll_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            trdy_q, tmt_q;
  logic            init_done;
  logic            accept, is_access, is_poll, acc_end, poll_hit, poll_fail, last_byte, gap_end;
  logic            unused_rd_bits;

  assign unused_rd_bits = ^{m_data_to_cpu[15:7], m_data_to_cpu[4:0]};

  assign word_ready = init_done && (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = word_valid && word_ready;
  assign is_access  = (state != IDLE) && (state != GAP);
  assign is_poll    = (state == POLL_TRDY) || (state == POLL_TMT);
  assign acc_end    = (phase == 2'd2);
  assign poll_hit   = (state == POLL_TRDY) ? trdy_q : tmt_q;
  assign poll_fail  = (poll_cnt == PW'(POLL_LIMIT-1));
  assign last_byte  = (byte_idx == BW'(NBYTES-1));
  assign gap_end    = (gap_cnt == GW'(LE_GAP-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept) state_nxt = SSEL_WR;
      SSEL_WR:   if (acc_end) state_nxt = CTRL_ON;
      CTRL_ON:   if (acc_end) state_nxt = POLL_TRDY;
      POLL_TRDY: if (acc_end) state_nxt = poll_hit ? DATA_WR : (poll_fail ? CTRL_OFF : POLL_TRDY);
      DATA_WR:   if (acc_end) state_nxt = last_byte ? POLL_TMT : POLL_TRDY;
      POLL_TMT:  if (acc_end) state_nxt = (poll_hit || poll_fail) ? CTRL_OFF : POLL_TMT;
      CTRL_OFF:  if (acc_end) state_nxt = CLR_STAT;
      CLR_STAT:  if (acc_end) state_nxt = GAP;
      GAP:       if (gap_end) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done   <= 1'b0;
      phase       <= 2'd0;
      shreg       <= '0;
      byte_idx    <= '0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      trdy_q      <= 1'b0;
      tmt_q       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      init_done <= 1'b1;
      phase     <= (is_access && !acc_end) ? phase + 2'd1 : 2'd0;
      gap_cnt   <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      // core read data is registered, so it is only valid at the end of the second strobe cycle
      if (is_access && phase == 2'd1) begin
        trdy_q <= m_data_to_cpu[6];
        tmt_q  <= m_data_to_cpu[5];
      end
      if (accept) begin
        shreg       <= word_data;
        byte_idx    <= '0;
        timeout_err <= 1'b0;
      end
      if (state == DATA_WR && acc_end) begin
        shreg <= {shreg[W-9:0], 8'h00};
        if (byte_idx != BW'(NBYTES)) byte_idx <= byte_idx + BW'(1);
      end
      if (state_nxt != state)      poll_cnt <= '0;
      else if (is_poll && acc_end) poll_cnt <= poll_cnt + PW'(1);
      if (is_poll && acc_end && !poll_hit && poll_fail) timeout_err <= 1'b1;
    end
  end

  // bus decode; the recovery cycle (phase 2) leaves every strobe high
  always_comb begin
    m_spi_select    = 1'b0;
    m_mem_addr      = 3'd0;
    m_data_from_cpu = 16'h0000;
    m_write_n       = 1'b1;
    m_read_n        = 1'b1;
    if (is_access && !acc_end) begin
      m_spi_select = 1'b1;
      case (state)
        SSEL_WR:   begin m_mem_addr = 3'd5; m_data_from_cpu = SLAVE_MASK; m_write_n = 1'b0; end
        CTRL_ON:   begin m_mem_addr = 3'd3; m_data_from_cpu = 16'h0400;   m_write_n = 1'b0; end
        POLL_TRDY,
        POLL_TMT:  begin m_mem_addr = 3'd2; m_read_n = 1'b0; end
        DATA_WR:   begin m_mem_addr = 3'd1; m_data_from_cpu = {8'h00, shreg[W-1 -: 8]}; m_write_n = 1'b0; end
        CTRL_OFF:  begin m_mem_addr = 3'd3; m_write_n = 1'b0; end
        CLR_STAT:  begin m_mem_addr = 3'd2; m_write_n = 1'b0; end
        default:   m_spi_select = 1'b0;
      endcase
    end
  end
endmodule
